// File: rtl/dma_controller_xfer.sv
// Single-engine DMA transfer block: moves one word per arbiter grant.
// Optional macro DMA_CONTROLLER_CIRC_MODE_EN enables circular reload.
module dma_controller_xfer #(
  parameter int CHANNELS_AMOUNT = 4,
  parameter int CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  input  logic [CHANNEL_CNT_W-1:0]          req_num_i,
  output logic                              ready_o,
  input  logic [CHANNELS_AMOUNT-1:0]        ch_start_i,
  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] cfg_src_addr_i,
  input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] cfg_dst_addr_i,
  input  logic [CHANNELS_AMOUNT*CNT_W-1:0]  cfg_cnt_i,
  input  logic [CHANNELS_AMOUNT-1:0]        cfg_src_inc_i,
  input  logic [CHANNELS_AMOUNT-1:0]        cfg_dst_inc_i,
  input  logic [CHANNELS_AMOUNT-1:0]        cfg_circ_i,
  output logic [ADDR_W-1:0]                 mm_address_o,
  output logic                              mm_read_o,
  output logic                              mm_write_o,
  output logic [DATA_W-1:0]                 mm_writedata_o,
  input  logic [DATA_W-1:0]                 mm_readdata_i,
  input  logic                              mm_readdatavalid_i,
  input  logic                              mm_waitrequest_i,
  output logic [CHANNELS_AMOUNT-1:0]        ch_active_o,
  output logic [CHANNELS_AMOUNT-1:0]        tc_o,
  output logic [CHANNELS_AMOUNT-1:0]        te_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RD_WAIT,
    WRITE,
    UPDATE
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  state_t                     state_q, state_d;
  logic [CHANNEL_CNT_W-1:0]   num_q, num_d;
  logic [ADDR_W-1:0]          src_q [CHANNELS_AMOUNT];
  logic [ADDR_W-1:0]          src_d [CHANNELS_AMOUNT];
  logic [ADDR_W-1:0]          dst_q [CHANNELS_AMOUNT];
  logic [ADDR_W-1:0]          dst_d [CHANNELS_AMOUNT];
  logic [CNT_W-1:0]           rem_q [CHANNELS_AMOUNT];
  logic [CNT_W-1:0]           rem_d [CHANNELS_AMOUNT];
  logic [CHANNELS_AMOUNT-1:0] act_q, act_d;
  logic [CHANNELS_AMOUNT-1:0] sinc_q, sinc_d;
  logic [CHANNELS_AMOUNT-1:0] dinc_q, dinc_d;
  logic                       rd_q, rd_d;
  logic                       wr_q, wr_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [CHANNELS_AMOUNT-1:0] tc_q, tc_d;
  logic [CHANNELS_AMOUNT-1:0] te_q, te_d;

  logic [ADDR_W-1:0] cfg_src [CHANNELS_AMOUNT];
  logic [ADDR_W-1:0] cfg_dst [CHANNELS_AMOUNT];
  logic [CNT_W-1:0]  cfg_cnt [CHANNELS_AMOUNT];
  logic              busy;
  logic [CNT_W-1:0]  rem_nx;

`ifdef DMA_CONTROLLER_CIRC_MODE_EN
  logic [CHANNELS_AMOUNT-1:0] circ_q, circ_d;
`else
  logic unused_circ;
  assign unused_circ = ^cfg_circ_i;
`endif

  assign ready_o        = (state_q == IDLE);
  assign mm_read_o      = rd_q;
  assign mm_write_o     = wr_q;
  assign mm_address_o   = addr_q;
  assign mm_writedata_o = wdata_q;
  assign ch_active_o    = act_q;
  assign tc_o           = tc_q;
  assign te_o           = te_q;

  // Split the flat configuration buses into per-channel views.
  always_comb begin
    for (int n = 0; n < CHANNELS_AMOUNT; n++) begin
      cfg_src[n] = cfg_src_addr_i[n*ADDR_W +: ADDR_W];
      cfg_dst[n] = cfg_dst_addr_i[n*ADDR_W +: ADDR_W];
      cfg_cnt[n] = cfg_cnt_i[n*CNT_W +: CNT_W];
    end
  end

  // Next-state: channel loads, transfer sequencing and registered bus outputs.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    act_d   = act_q;
    sinc_d  = sinc_q;
    dinc_d  = dinc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tc_d    = '0;
    te_d    = '0;
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
    circ_d  = circ_q;
`endif
    busy    = (state_q != IDLE);
    rem_nx  = rem_q[num_q] - CNT_W'(1);

    // The channel being moved keeps its working set until it is done.
    for (int n = 0; n < CHANNELS_AMOUNT; n++) begin
      if (ch_start_i[n] &&
          !(busy && num_q == CHANNEL_CNT_W'(n))) begin
        src_d[n]  = cfg_src[n];
        dst_d[n]  = cfg_dst[n];
        rem_d[n]  = cfg_cnt[n];
        act_d[n]  = |cfg_cnt[n];
        sinc_d[n] = cfg_src_inc_i[n];
        dinc_d[n] = cfg_dst_inc_i[n];
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
        circ_d[n] = cfg_circ_i[n];
`endif
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          num_d = req_num_i;
          if (act_q[req_num_i]) begin
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = src_q[req_num_i];
          end else begin
            te_d[req_num_i] = 1'b1;
          end
        end
      end
      READ: begin
        if (!mm_waitrequest_i) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mm_readdatavalid_i) begin
          wdata_d = mm_readdata_i;
          wr_d    = 1'b1;
          addr_d  = dst_q[num_q];
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!mm_waitrequest_i) begin
          wr_d    = 1'b0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d       = IDLE;
        rem_d[num_q]  = rem_nx;
        if (sinc_q[num_q])
          src_d[num_q] = src_q[num_q] + STEP;
        if (dinc_q[num_q])
          dst_d[num_q] = dst_q[num_q] + STEP;
        if (rem_nx == '0) begin
          tc_d[num_q]  = 1'b1;
          act_d[num_q] = 1'b0;
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
          if (circ_q[num_q]) begin
            src_d[num_q] = cfg_src[num_q];
            dst_d[num_q] = cfg_dst[num_q];
            rem_d[num_q] = cfg_cnt[num_q];
            act_d[num_q] = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working-register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      num_q   <= '0;
      act_q   <= '0;
      sinc_q  <= '0;
      dinc_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tc_q    <= '0;
      te_q    <= '0;
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
      circ_q  <= '0;
`endif
      for (int n = 0; n < CHANNELS_AMOUNT; n++) begin
        src_q[n] <= '0;
        dst_q[n] <= '0;
        rem_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      act_q   <= act_d;
      sinc_q  <= sinc_d;
      dinc_q  <= dinc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tc_q    <= tc_d;
      te_q    <= te_d;
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
      circ_q  <= circ_d;
`endif
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_dma_controller_xfer.sv
// Scoreboard bench for dma_controller_xfer: random grants over a
// word-level channel model, plus directed timing/wait/reset cases.
module tb_dma_controller_xfer;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 16;
`ifdef DMA_CONTROLLER_CIRC_MODE_EN
  localparam bit CIRC_EN = 1'b1;
`else
  localparam bit CIRC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic [1:0]      req_num_i;
  logic            ready_o;
  logic [NCH-1:0]  ch_start_i;
  logic [NCH*AW-1:0] cfg_src_addr_i;
  logic [NCH*AW-1:0] cfg_dst_addr_i;
  logic [NCH*CW-1:0] cfg_cnt_i;
  logic [NCH-1:0]  cfg_src_inc_i;
  logic [NCH-1:0]  cfg_dst_inc_i;
  logic [NCH-1:0]  cfg_circ_i;
  logic [AW-1:0]   mm_address_o;
  logic            mm_read_o;
  logic            mm_write_o;
  logic [DW-1:0]   mm_writedata_o;
  logic [DW-1:0]   mm_readdata_i;
  logic            mm_readdatavalid_i;
  logic            mm_waitrequest_i;
  logic [NCH-1:0]  ch_active_o;
  logic [NCH-1:0]  tc_o;
  logic [NCH-1:0]  te_o;

  dma_controller_xfer dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_num_i          (req_num_i),
    .ready_o            (ready_o),
    .ch_start_i         (ch_start_i),
    .cfg_src_addr_i     (cfg_src_addr_i),
    .cfg_dst_addr_i     (cfg_dst_addr_i),
    .cfg_cnt_i          (cfg_cnt_i),
    .cfg_src_inc_i      (cfg_src_inc_i),
    .cfg_dst_inc_i      (cfg_dst_inc_i),
    .cfg_circ_i         (cfg_circ_i),
    .mm_address_o       (mm_address_o),
    .mm_read_o          (mm_read_o),
    .mm_write_o         (mm_write_o),
    .mm_writedata_o     (mm_writedata_o),
    .mm_readdata_i      (mm_readdata_i),
    .mm_readdatavalid_i (mm_readdatavalid_i),
    .mm_waitrequest_i   (mm_waitrequest_i),
    .ch_active_o        (ch_active_o),
    .tc_o               (tc_o),
    .te_o               (te_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Memory contents seen by the engine: a fixed hash of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  typedef struct {
    bit          te;
    int          ch;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          tc;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] m_src [NCH];
  logic [31:0] m_dst [NCH];
  int          m_rem [NCH];
  bit          m_act [NCH];
  bit          m_si  [NCH];
  bit          m_di  [NCH];
  bit          m_circ[NCH];
  logic [31:0] c_src [NCH];
  logic [31:0] c_dst [NCH];
  int          c_cnt [NCH];

  // Word-level channel model: one grant moves one word or reports an error.
  task automatic model_grant(input int ch);
    exp_t e;
    e.ch = ch;
    e.ra = '0;
    e.wa = '0;
    e.wd = '0;
    e.tc = 1'b0;
    if (!m_act[ch]) begin
      e.te = 1'b1;
      sbq.push_back(e);
      return;
    end
    e.te = 1'b0;
    e.ra = m_src[ch];
    e.wa = m_dst[ch];
    e.wd = mem_f(m_src[ch]);
    m_rem[ch]--;
    e.tc = (m_rem[ch] == 0);
    if (m_si[ch]) m_src[ch] = m_src[ch] + 32'd4;
    if (m_di[ch]) m_dst[ch] = m_dst[ch] + 32'd4;
    if (m_rem[ch] == 0) begin
      if (CIRC_EN && m_circ[ch]) begin
        m_src[ch] = c_src[ch];
        m_dst[ch] = c_dst[ch];
        m_rem[ch] = c_cnt[ch];
      end else begin
        m_act[ch] = 1'b0;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic drive_cfg(input int ch, input logic [31:0] s,
                           input logic [31:0] d, input int cnt,
                           input bit si, input bit di, input bit circ);
    cfg_src_addr_i[ch*AW +: AW] = s;
    cfg_dst_addr_i[ch*AW +: AW] = d;
    cfg_cnt_i[ch*CW +: CW]      = CW'(cnt);
    cfg_src_inc_i[ch]           = si;
    cfg_dst_inc_i[ch]           = di;
    cfg_circ_i[ch]              = circ;
    c_src[ch] = s;
    c_dst[ch] = d;
    c_cnt[ch] = cnt;
  endtask

  // Called at #1 after a posedge with the engine idle.
  task automatic load_ch(input int ch, input logic [31:0] s,
                         input logic [31:0] d, input int cnt,
                         input bit si, input bit di, input bit circ);
    drive_cfg(ch, s, d, cnt, si, di, circ);
    ch_start_i[ch] = 1'b1;
    @(posedge clk); #1;
    ch_start_i = '0;
    m_src[ch]  = s;
    m_dst[ch]  = d;
    m_rem[ch]  = cnt;
    m_act[ch]  = (cnt != 0);
    m_si[ch]   = si;
    m_di[ch]   = di;
    m_circ[ch] = circ;
  endtask

  // Issue one grant; optionally re-start the same channel mid-transfer,
  // which must be ignored apart from the new cfg values.
  task automatic grant(input int ch, input bit poke, output int busy);
    bit          do_poke;
    logic [31:0] ns;
    logic [31:0] nd;
    int          nc;
    do_poke = poke && m_act[ch];
    ns = $urandom & 32'hFFFF_FFFC;
    nd = $urandom & 32'hFFFF_FFFC;
    nc = $urandom_range(1, 5);
    if (do_poke) begin
      c_src[ch] = ns;
      c_dst[ch] = nd;
      c_cnt[ch] = nc;
    end
    model_grant(ch);
    req_valid_i = 1'b1;
    req_num_i   = 2'(ch);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (do_poke) begin
      drive_cfg(ch, ns, nd, nc, 1'($urandom), 1'($urandom), 1'($urandom));
      ch_start_i[ch] = 1'b1;
      @(posedge clk); #1;
      ch_start_i = '0;
    end
    busy = 0;
    while (!ready_o && busy < 200) begin
      @(posedge clk); #1;
      busy++;
    end
    chk("ready_timeout", busy >= 200, 0);
  endtask

  // Bus slave: waitrequest per mode, read data after a read is accepted.
  // mode 0: no stalls; 1: random stalls/latency/stray valids;
  // 2: 3 stall cycles on read, 2 on write; 3: read latency of 4 cycles.
  int          mode = 0;
  int          rdv_delay = -1;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  logic [31:0] rd_lat;

  initial begin
    mm_readdata_i      = '0;
    mm_readdatavalid_i = 1'b0;
    mm_waitrequest_i   = 1'b0;
    forever begin
      bit pend;
      @(posedge clk); #1;
      pend = (rdv_delay >= 0);
      mm_readdatavalid_i = 1'b0;
      mm_readdata_i      = $urandom;
      if (rdv_delay == 0) begin
        mm_readdatavalid_i = 1'b1;
        mm_readdata_i      = mem_f(rd_lat);
      end
      if (rdv_delay >= 0) rdv_delay--;
      if (!pend && mode == 1 && $urandom_range(0, 3) == 0)
        mm_readdatavalid_i = 1'b1;
      rd_cyc = mm_read_o ? rd_cyc + 1 : 0;
      wr_cyc = mm_write_o ? wr_cyc + 1 : 0;
      case (mode)
        1:       mm_waitrequest_i = ($urandom_range(0, 2) == 0);
        2:       mm_waitrequest_i = (mm_read_o && rd_cyc <= 3) ||
                                    (mm_write_o && wr_cyc <= 2);
        default: mm_waitrequest_i = 1'b0;
      endcase
      if (mm_read_o && !mm_waitrequest_i) begin
        rd_lat    = mm_address_o;
        rdv_delay = (mode == 1) ? $urandom_range(0, 2) :
                    (mode == 3) ? 3 : 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each completed write or error pulse.
  bit          mon_en = 1'b0;
  bit          prev_rdw = 1'b0;
  bit          prev_wrw = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [31:0] last_rd;
  bit          rd_seen = 1'b0;
  int          tc_due = -1;
  logic [3:0]  tc_mask = '0;

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] etc;
    if (mon_en) begin
      etc = (tc_due == 0) ? tc_mask : 4'b0;
      if (tc_o != 0 || etc != 0) chk("tc", tc_o, etc);
      if (tc_due >= 0) tc_due--;
      if (mm_read_o || mm_write_o)
        chk("rd_wr_overlap", mm_read_o & mm_write_o, 0);
      if (prev_rdw) begin
        chk("rd_hold_strobe", mm_read_o, 1);
        chk("rd_hold_addr", mm_address_o, prev_addr);
      end
      if (prev_wrw) begin
        chk("wr_hold_strobe", mm_write_o, 1);
        chk("wr_hold_addr", mm_address_o, prev_addr);
        chk("wr_hold_data", mm_writedata_o, prev_data);
      end
      prev_rdw  = mm_read_o && mm_waitrequest_i;
      prev_wrw  = mm_write_o && mm_waitrequest_i;
      prev_addr = mm_address_o;
      prev_data = mm_writedata_o;
      if (mm_read_o && !mm_waitrequest_i) begin
        chk("single_read", rd_seen, 0);
        rd_seen = 1'b1;
        last_rd = mm_address_o;
      end
      if (mm_write_o && !mm_waitrequest_i) begin
        chk("sb_nonempty_wr", sbq.size() == 0, 0);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("xfer_kind", e.te, 0);
          chk("rd_addr", last_rd, e.ra);
          chk("wr_addr", mm_address_o, e.wa);
          chk("wr_data", mm_writedata_o, e.wd);
          chk("rd_before_wr", rd_seen, 1);
          tc_due  = 1;
          tc_mask = e.tc ? (4'b1 << e.ch) : 4'b0;
        end
        rd_seen = 1'b0;
      end
      if (te_o != 0) begin
        chk("sb_nonempty_te", sbq.size() == 0, 0);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("te_kind", e.te, 1);
          chk("te_ch", te_o, 4'b1 << e.ch);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int  b;
    bit  r_rd [6];
    bit  r_wr [6];
    bit  r_rdy[6];
    bit  strobes;
    bit  rdv_seen;
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_num_i      = '0;
    ch_start_i     = '0;
    cfg_src_addr_i = '0;
    cfg_dst_addr_i = '0;
    cfg_cnt_i      = '0;
    cfg_src_inc_i  = '0;
    cfg_dst_inc_i  = '0;
    cfg_circ_i     = '0;
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 1'b0;
      m_rem[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    chk("rst_ready", ready_o, 1);
    chk("rst_read", mm_read_o, 0);
    chk("rst_write", mm_write_o, 0);
    chk("rst_addr", mm_address_o, 0);
    chk("rst_wdata", mm_writedata_o, 0);
    chk("rst_active", ch_active_o, 0);
    chk("rst_tc", tc_o, 0);
    chk("rst_te", te_o, 0);
    mon_en = 1'b1;

    // Two-word incrementing transfer on channel 0.
    load_ch(0, 32'h100, 32'h200, 2, 1, 1, 0);
    chk("ch0_loaded", ch_active_o[0], 1);
    grant(0, 0, b);
    grant(0, 0, b);
    drain();
    chk("ch0_done", ch_active_o[0], 0);

    // Zero-wait latency from accept.
    load_ch(1, 32'h40, 32'h80, 1, 1, 0, 0);
    model_grant(1);
    req_valid_i = 1'b1;
    req_num_i   = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      r_rd[k]  = mm_read_o;
      r_wr[k]  = mm_write_o;
      r_rdy[k] = ready_o;
    end
    chk("lat_read_t1", r_rd[1], 1);
    chk("lat_read_t2", r_rd[2], 0);
    chk("lat_write_t3", r_wr[3], 1);
    chk("lat_ready_t4", r_rdy[4], 0);
    chk("lat_ready_t5", r_rdy[5], 1);
    drain();

    // Scripted stalls: 3 on read, 2 on write.
    mode = 2;
    load_ch(3, 32'h1000, 32'h2000, 1, 1, 1, 0);
    grant(3, 0, b);
    chk("stall_busy", b, 9);
    mode = 0;
    drain();

    // Grant to an empty channel.
    load_ch(2, 32'h0, 32'h0, 0, 1, 1, 0);
    grant(2, 0, b);
    chk("te_no_busy", b, 0);
    drain();

    // Single-word channel with circular bit.
    load_ch(0, 32'h100, 32'h300, 1, 1, 1, 1);
    grant(0, 0, b);
    grant(0, 0, b);
    drain();
    chk("circ_active", ch_active_o[0], CIRC_EN);

    // Randomized traffic.
    mode = 1;
    for (int c = 0; c < NCH; c++)
      load_ch(c, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              $urandom_range(1, 4), 1'($urandom), 1'($urandom),
              1'($urandom));
    for (int it = 0; it < 150; it++) begin
      int ch;
      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] s;
        s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 :
            ($urandom & 32'hFFFF_FFFC);
        load_ch(ch, s, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 5),
                1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        grant(ch, $urandom_range(0, 3) == 0, b);
      end
    end
    drain();
    for (int c = 0; c < NCH; c++)
      chk("active_final", ch_active_o[c], m_act[c]);

    // Reset while waiting for read data.
    mon_en = 1'b0;
    mode   = 3;
    load_ch(1, 32'h500, 32'h600, 3, 1, 1, 0);
    req_valid_i = 1'b1;
    req_num_i   = 2'd1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rdwait_idle_bus", {mm_read_o, mm_write_o, ready_o}, 0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rstmid_ready", ready_o, 1);
    chk("rstmid_read", mm_read_o, 0);
    chk("rstmid_write", mm_write_o, 0);
    chk("rstmid_active", ch_active_o, 0);
    strobes  = 1'b0;
    rdv_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      strobes  = strobes | mm_read_o | mm_write_o;
      rdv_seen = rdv_seen | mm_readdatavalid_i;
    end
    chk("late_rdv_issued", rdv_seen, 1);
    chk("late_rdv_ignored", strobes, 0);
    chk("rstmid_ready_end", ready_o, 1);
    chk("rstmid_tc", tc_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
